ha_serial_add_ctrl: RTL
=======================

// Module: ha_serial_add_ctrl
// PURPOSE
//   Bit-serial N-bit adder sequencer built around ONE shared half-adder cell.
//   Each operand bit takes two phases through the same cell:
//   - PH_A: a_i ^ b_i, giving partial sum s1 and partial carry c1.
//   - PH_B: s1 ^ carry, giving sum_i and c2.
//   - The running carry then becomes c1 | c2.
//   Trades latency for area. Sits between an operand producer and a result
//   consumer, with valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   start_valid  in   1      operand set valid
//   start_ready  out  1      block can accept operands (state==IDLE)
//   op_a         in   WIDTH  operand A
//   op_b         in   WIDTH  operand B
//   cin          in   1      carry-in
//   res_valid    out  1      result valid, held until consumed
//   res_ready    in   1      consumer accepts result
//   res_sum      out  WIDTH  op_a + op_b + cin, modulo 2^WIDTH
//   res_cout     out  1      carry-out of MSB
//   busy         out  1      1 in PH_A/PH_B
// BEHAVIOUR
//   - One clock domain. rst_n is asynchronous assert, synchronous deassert
//     (synchronised upstream).
//   - Reset values: state=IDLE, res_valid=0, res_sum=0, res_cout=0, busy=0,
//     bit index=0, carry=0. start_ready=1 (combinational from IDLE).
//   - FSM states: IDLE, PH_A, PH_B, DONE.
//     - IDLE: on start_valid&&start_ready, latch op_a, op_b and cin
//       (cin goes into the carry register), set idx=0, go to PH_A.
//       Later changes on op_a/op_b/cin are ignored until the next accept.
//     - PH_A: drive the cell with a[idx], b[idx]; register s1, c1; go to PH_B.
//     - PH_B: drive the cell with s1, carry.
//       - Write sum[idx]=cell sum; carry <= c1|cell carry.
//       - If idx==WIDTH-1: res_cout<=new carry, res_valid<=1, go to DONE.
//       - Else idx<=idx+1 and go to PH_A.
//     - DONE: hold res_valid, res_sum and res_cout stable. On res_ready,
//       res_valid<=0 and go to IDLE.
//   - Latency: res_valid rises on the 2*WIDTH-th rising edge after the
//     accepting edge (WIDTH=8 -> 16 edges).
//   - Throughput: one op per 2*WIDTH+2 cycles minimum. No overlap: start_ready=0
//     in PH_A, PH_B and DONE.
//   - res_sum/res_cout keep the last result after handshake, until the next
//     accept. Bits of res_sum may be updated during a new operation;
//     consumers sample only while res_valid=1.
//   - Wrap-around: the sum is modulo 2^WIDTH; overflow shows only via res_cout.
//   - Reset mid-operation: the operation is aborted and all registers return
//     to their reset values. No partial result is ever flagged valid.
//   - start_valid during DONE, or in the same cycle as res_ready, is not
//     accepted. It is accepted the following cycle in IDLE if still asserted.
//   - The cell is purely combinational; every datapath register is in this
//     block.
// CONFIGURATION
//   - HA_SERIAL_OVF_EN defined: adds output port res_ovf (1 bit, reset 0).
//     - res_ovf = carry into the MSB XOR res_cout, captured in the last PH_B.
//     - Valid with res_valid (signed two's-complement overflow).
//   - HA_SERIAL_OVF_EN undefined: no res_ovf port and no extra register.
//     All other behaviour is identical.
// STRUCTURE
//   - Package ha_serial_pkg holds:
//     - ha_state_t enum {IDLE, PH_A, PH_B, DONE}, 2-bit encoding.
//     - Constant HA_PHASES_PER_BIT=2.
//     - Function for index width $clog2(WIDTH).
//   - Sub-module ha_cell (inputs x, y; outputs s=x^y, c=x&y) is instantiated
//     exactly once. A second instance is a spec violation.
// TESTING  (WIDTH=8 unless noted)
//   1. a=0x00,b=0x00,cin=0 -> sum=0x00, cout=0; res_valid exactly 16 edges
//      after the accept.
//   2. a=0xFF,b=0x01,cin=0 -> sum=0x00, cout=1 (wrap).
//      a=0x5A,b=0xA5,cin=1 -> sum=0x00, cout=1.
//   3. Backpressure: hold res_ready=0 for 5 cycles in DONE ->
//      res_valid/sum/cout stable, start_ready=0. Pulses on start_valid are
//      ignored; the op is accepted only after the handshake and return to IDLE.
//   4. Assert rst_n=0 at idx=3 of a=0x3C+0x0F -> all outputs at reset values
//      immediately. A next op 0x12+0x34 -> 0x46, cout=0.
//   5. Randomised back-to-back ops with a reference model in the bench:
//      sum and cout match; busy=1 exactly 2*WIDTH cycles per op.
//   6. With HA_SERIAL_OVF_EN: 0x7F+0x01 -> ovf=1; 0xFF+0x01 -> ovf=0;
//      0x80+0x80 -> ovf=1, cout=1.

Source files
------------

// File: rtl/ha_serial_pkg.sv
// ha_serial_pkg: shared types and constants for the bit-serial half-adder sequencer
//   ha_state_t        : FSM state encoding (IDLE, PH_A, PH_B, DONE)
//   HA_PHASES_PER_BIT : cell passes spent on each operand bit
//   ha_idx_w()        : bit-index register width for a given operand width
package ha_serial_pkg;
  typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} ha_state_t;
  localparam int HA_PHASES_PER_BIT = 2;
  function automatic int ha_idx_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/ha_serial_add_ctrl_cell.sv
// ha_cell: purely combinational half-adder cell
//   x, y : input bits
//   s    : x ^ y
//   c    : x & y
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/ha_serial_add_ctrl.sv
// ha_serial_add_ctrl: bit-serial WIDTH-bit adder sharing one half-adder cell over two phases per bit
//   clk, rst_n             : clock, asynchronous active-low reset
//   start_valid/ready, op_a, op_b, cin : operand handshake
//   res_valid/ready, res_sum, res_cout : result handshake, result held until consumed
//   busy                   : high while the cell is in use (PH_A/PH_B)
//   res_ovf                : signed overflow, present only with HA_SERIAL_OVF_EN defined
import ha_serial_pkg::*;
module ha_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
`ifdef HA_SERIAL_OVF_EN
  output logic             res_ovf,
`endif
  output logic             busy
);
  localparam int IW = ha_idx_w(WIDTH);
  ha_state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, s1, c1, cx, cy, cs, cc, last, new_c;
  // PH_A feeds the operand bits, PH_B feeds the partial sum and running carry
  assign cx = state == PH_A ? a_r[idx] : s1;
  assign cy = state == PH_A ? b_r[idx] : carry;
  assign last = idx == IW'(WIDTH - 1);
  assign new_c = c1 | cc;
  assign start_ready = state == IDLE;
  assign busy = state == PH_A || state == PH_B;
  ha_cell u_cell (.x(cx), .y(cy), .s(cs), .c(cc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start_valid ? PH_A : IDLE;
      PH_A: nxt = PH_B;
      PH_B: nxt = last ? DONE : PH_A;
      DONE: nxt = res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      s1 <= 1'b0;
      c1 <= 1'b0;
      res_sum <= '0;
      res_cout <= 1'b0;
      res_valid <= 1'b0;
`ifdef HA_SERIAL_OVF_EN
      res_ovf <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start_valid) begin
        a_r <= op_a;
        b_r <= op_b;
        carry <= cin;
        idx <= '0;
      end
      if (state == PH_A) begin
        s1 <= cs;
        c1 <= cc;
      end
      if (state == PH_B) begin
        res_sum[idx] <= cs;
        carry <= new_c;
        idx <= last ? idx : idx + IW'(1);
        if (last) begin
          res_cout <= new_c;
          res_valid <= 1'b1;
`ifdef HA_SERIAL_OVF_EN
          // carry still holds the carry into the MSB during the last PH_B
          res_ovf <= carry ^ new_c;
`endif
        end
      end
      if (state == DONE && res_ready) res_valid <= 1'b0;
    end
endmodule
